analog_mux_ctrl: RTL and testbench



---
 rtl/analog_mux_ctrl.sv | 178 +++++++++++++++++
 tb/tb_analog_mux_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_mux_ctrl.sv
// analog_mux_ctrl: break-before-make sequencer for the bandgap analog mux.
// At most one active-low channel enable is ever low. Every change of the
// closed channel goes through an all-open BREAK interval of BREAK_CYC cycles.
// A host select handshake and an autonomous round-robin scan share one FSM.
module analog_mux_ctrl #(
   parameter int N_CH      = 32,
   parameter int SEL_W     = 5,
   parameter int BREAK_CYC = 4,
   parameter int DWELL_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               off_req,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [SEL_W-1:0]   req_sel,
   input  logic               scan_en,
   input  logic [SEL_W-1:0]   scan_first,
   input  logic [SEL_W-1:0]   scan_last,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N_CH-1:0]    en_b,
   output logic               s_en,
   output logic               s_en_b,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               settled,
   output logic               sample_pulse,
   output logic               err
);

   // One counter serves both the break dead time and the scan dwell.
   localparam int BRK_W = $clog2(BREAK_CYC + 1);
   localparam int CNT_W = (DWELL_W > BRK_W) ? DWELL_W : BRK_W;
   localparam logic [CNT_W-1:0] BRK_LOAD = CNT_W'(BREAK_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // Channel count held one bit wider than a select so N_CH == 2**SEL_W fits.
   localparam logic [SEL_W:0]   N_CH_V   = (SEL_W + 1)'(N_CH);

   typedef enum logic [1:0] {S_OFF, S_BREAK, S_ON, S_SCAN_ON} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [SEL_W-1:0]  cur_sel_reg, cur_sel_next;
   logic              scan_mode_reg, scan_mode_next;
   logic              scan_en_d_reg;
   logic              err_next;
   logic              closed_next;
   logic [N_CH-1:0]   en_b_next;
   logic [N_CH-1:0]   en_b_reg;
   logic              s_en_reg, s_en_b_reg, settled_reg;
   logic              sample_pulse_reg, err_reg, req_ready_reg;

   logic              scan_rise;
   logic              range_bad;
   logic              sel_bad;
   logic              handshake;
   logic [CNT_W-1:0]  dwell_load;

   assign scan_rise  = scan_en & ~scan_en_d_reg;
   assign range_bad  = (scan_first > scan_last) || ({1'b0, scan_last} >= N_CH_V);
   assign sel_bad    = ({1'b0, req_sel} >= N_CH_V);
   assign handshake  = req_valid & req_ready_reg;
   // A zero dwell still closes the channel for one cycle.
   assign dwell_load = (dwell == '0) ? CNT_ONE : CNT_W'(dwell);

   // Next-state logic: off_req > scan entry > select request.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      cur_sel_next   = cur_sel_reg;
      scan_mode_next = scan_mode_reg;
      err_next       = 1'b0;
      if (off_req) begin
         state_next     = S_OFF;
         scan_mode_next = 1'b0;
      end else begin
         case (state_reg)
            S_OFF, S_ON: begin
               if (scan_rise) begin
                  if (range_bad) begin
                     err_next = 1'b1;
                  end else begin
                     state_next     = S_BREAK;
                     cnt_next       = BRK_LOAD;
                     cur_sel_next   = scan_first;
                     scan_mode_next = 1'b1;
                  end
               end else if (handshake) begin
                  if (sel_bad) begin
                     err_next = 1'b1;
                  end else if (!(state_reg == S_ON && req_sel == cur_sel_reg)) begin
                     state_next     = S_BREAK;
                     cnt_next       = BRK_LOAD;
                     cur_sel_next   = req_sel;
                     scan_mode_next = 1'b0;
                  end
               end
            end
            S_BREAK: begin
               if (cnt_reg == CNT_ONE) begin
                  if (scan_mode_reg) begin
                     state_next = S_SCAN_ON;
                     cnt_next   = dwell_load;
                  end else begin
                     state_next = S_ON;
                  end
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            S_SCAN_ON: begin
               if (cnt_reg == CNT_ONE) begin
                  if (scan_en) begin
                     state_next   = S_BREAK;
                     cnt_next     = BRK_LOAD;
                     cur_sel_next = (cur_sel_reg >= scan_last) ? scan_first
                                                              : cur_sel_reg + SEL_W'(1);
                  end else begin
                     // Scan stopped: keep the present channel closed, no break.
                     state_next     = S_ON;
                     scan_mode_next = 1'b0;
                  end
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            default: state_next = S_OFF;
         endcase
      end
   end

   assign closed_next = (state_next == S_ON) || (state_next == S_SCAN_ON);

   // Per-channel enable decode from the next state so en_b is a plain register.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_en_b
      assign en_b_next[gi] = ~(closed_next && (cur_sel_next == SEL_W'(gi)));
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= S_OFF;
         cnt_reg          <= '0;
         cur_sel_reg      <= '0;
         scan_mode_reg    <= 1'b0;
         scan_en_d_reg    <= 1'b0;
         en_b_reg         <= '1;
         s_en_reg         <= 1'b0;
         s_en_b_reg       <= 1'b1;
         settled_reg      <= 1'b0;
         sample_pulse_reg <= 1'b0;
         err_reg          <= 1'b0;
         req_ready_reg    <= 1'b1;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         cur_sel_reg      <= cur_sel_next;
         scan_mode_reg    <= scan_mode_next;
         scan_en_d_reg    <= scan_en;
         en_b_reg         <= en_b_next;
         s_en_reg         <= closed_next;
         s_en_b_reg       <= ~closed_next;
         settled_reg      <= closed_next;
         sample_pulse_reg <= (state_next == S_SCAN_ON) && (cnt_next == CNT_ONE);
         err_reg          <= err_next;
         req_ready_reg    <= (state_next == S_OFF) || ((state_next == S_ON) && !scan_en);
      end
   end

   assign en_b         = en_b_reg;
   assign s_en         = s_en_reg;
   assign s_en_b       = s_en_b_reg;
   assign cur_sel      = cur_sel_reg;
   assign settled      = settled_reg;
   assign sample_pulse = sample_pulse_reg;
   assign err          = err_reg;
   assign req_ready    = req_ready_reg;

endmodule

// File: tb/tb_analog_mux_ctrl.sv
// Directed testbench for analog_mux_ctrl (N_CH=32, SEL_W=6, BREAK_CYC=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_analog_mux_ctrl;

   localparam int N_CH      = 32;
   localparam int SEL_W     = 6;
   localparam int BREAK_CYC = 4;
   localparam int DWELL_W   = 16;
   localparam logic [N_CH-1:0] ALL_OPEN = '1;

   logic               clk = 1'b0;
   logic               reset, off_req, req_valid, req_ready, scan_en;
   logic               s_en, s_en_b, settled, sample_pulse, err;
   logic [SEL_W-1:0]   req_sel, scan_first, scan_last, cur_sel;
   logic [DWELL_W-1:0] dwell;
   logic [N_CH-1:0]    en_b;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   analog_mux_ctrl #(
      .N_CH(N_CH), .SEL_W(SEL_W), .BREAK_CYC(BREAK_CYC), .DWELL_W(DWELL_W)
   ) dut (
      .clk(clk), .reset(reset), .off_req(off_req), .req_valid(req_valid),
      .req_ready(req_ready), .req_sel(req_sel), .scan_en(scan_en),
      .scan_first(scan_first), .scan_last(scan_last), .dwell(dwell),
      .en_b(en_b), .s_en(s_en), .s_en_b(s_en_b), .cur_sel(cur_sel),
      .settled(settled), .sample_pulse(sample_pulse), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [N_CH-1:0] one_low(input int ch);
      logic [N_CH-1:0] v;
      v     = '1;
      v[ch] = 1'b0;
      return v;
   endfunction

   // Every cycle: at most one switch closed, s_en_b complements s_en, settled tracks s_en.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ($countones(~en_b) > 1 || s_en_b !== ~s_en || settled !== s_en) begin
            errors++;
            $display("FAIL invariant en_b=%h s_en=%b s_en_b=%b settled=%b (need <=1 low, s_en_b=~s_en, settled=s_en)",
                     en_b, s_en, s_en_b, settled);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; off_req = 1'b0; req_valid = 1'b0; req_sel = '0;
      scan_en = 1'b0; scan_first = '0; scan_last = '0; dwell = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({en_b, s_en, s_en_b, settled, req_ready, sample_pulse, err, cur_sel} !==
          {ALL_OPEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {SEL_W{1'b0}}}) begin
         errors++;
         $display("FAIL reset en_b=%h s_en=%b s_en_b=%b settled=%b rdy=%b sp=%b err=%b sel=%0d need all1/0/1/0/1/0/0/0",
                  en_b, s_en, s_en_b, settled, req_ready, sample_pulse, err, cur_sel);
      end
      reset  = 1'b0;
      mon_en = 1'b1;
      $display("reset done");
   endtask

   // Handshake for channel sel; prev is the channel expected closed beforehand (-1 = none).
   task automatic test_select(input int sel, input int prev);
      logic [N_CH-1:0] exp_en;
      checks++;
      if (en_b !== ((prev < 0) ? ALL_OPEN : one_low(prev)) || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL select%0d_pre en_b=%h rdy=%b prev=%0d", sel, en_b, req_ready, prev);
      end
      req_sel   = SEL_W'(sel);
      req_valid = 1'b1;
      for (int i = 1; i <= BREAK_CYC + 1; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         exp_en = (i <= BREAK_CYC) ? ALL_OPEN : one_low(sel);
         checks++;
         if (en_b !== exp_en || s_en !== (i > BREAK_CYC) || settled !== (i > BREAK_CYC)) begin
            errors++;
            $display("FAIL select%0d_cyc%0d en_b=%h s_en=%b settled=%b need en_b=%h s_en=%b",
                     sel, i, en_b, s_en, settled, exp_en, (i > BREAK_CYC));
         end
      end
      checks++;
      if (cur_sel !== SEL_W'(sel) || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL select%0d_cur cur_sel=%0d rdy=%b need %0d/1", sel, cur_sel, req_ready, sel);
      end
      $display("select %0d accepted and closed", sel);
   endtask

   task automatic test_noop();
      req_sel   = SEL_W'(17);
      req_valid = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         checks++;
         if (en_b !== one_low(17) || s_en !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL noop_cyc%0d en_b=%h s_en=%b rdy=%b need %h/1/1", i, en_b, s_en, req_ready, one_low(17));
         end
      end
      $display("reselect 17 no-op");
   endtask

   task automatic test_bad_sel();
      req_sel   = SEL_W'(40);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || en_b !== one_low(17) || cur_sel !== SEL_W'(17)) begin
         errors++;
         $display("FAIL bad_sel_err err=%b en_b=%h cur_sel=%0d need 1/%h/17", err, en_b, cur_sel, one_low(17));
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || en_b !== one_low(17) || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bad_sel_after err=%b en_b=%h rdy=%b need 0/%h/1", err, en_b, req_ready, one_low(17));
      end
      $display("select 40 rejected");
   endtask

   task automatic test_scan();
      logic [N_CH-1:0] exp_en;
      logic exp_sp;
      int ph, ch;
      scan_first = SEL_W'(30);
      scan_last  = SEL_W'(31);
      dwell      = DWELL_W'(3);
      scan_en    = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c <= 21) begin
            ph     = (c - 1) % 7;
            ch     = (((c - 1) / 7) % 2 == 1) ? 31 : 30;
            exp_en = (ph < 4) ? ALL_OPEN : one_low(ch);
            exp_sp = (ph == 6);
         end else begin
            exp_en = one_low(30);
            exp_sp = 1'b0;
         end
         checks++;
         if (en_b !== exp_en || sample_pulse !== exp_sp) begin
            errors++;
            $display("FAIL scan_cyc%0d en_b=%h sp=%b need %h/%b", c, en_b, sample_pulse, exp_en, exp_sp);
         end
         if (c == 19) scan_en = 1'b0;
      end
      checks++;
      if (cur_sel !== SEL_W'(30) || req_ready !== 1'b1 || settled !== 1'b1) begin
         errors++;
         $display("FAIL scan_exit cur_sel=%0d rdy=%b settled=%b need 30/1/1", cur_sel, req_ready, settled);
      end
      $display("scan 30..31 dwell 3, exit on 30");
   endtask

   task automatic test_off_break();
      req_sel   = SEL_W'(5);
      req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (en_b !== ALL_OPEN || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL off_break_in en_b=%h rdy=%b need all1/0", en_b, req_ready);
      end
      req_sel = SEL_W'(9);
      off_req = 1'b1;
      @(negedge clk);
      off_req   = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (en_b !== ALL_OPEN || settled !== 1'b0 || req_ready !== 1'b1 || cur_sel !== SEL_W'(5)) begin
         errors++;
         $display("FAIL off_break_off en_b=%h settled=%b rdy=%b cur_sel=%0d need all1/0/1/5",
                  en_b, settled, req_ready, cur_sel);
      end
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (en_b !== ALL_OPEN || cur_sel !== SEL_W'(5)) begin
            errors++;
            $display("FAIL off_break_hold%0d en_b=%h cur_sel=%0d need all1/5", i, en_b, cur_sel);
         end
      end
      $display("off_req aborted break");
   endtask

   task automatic test_bad_scan();
      scan_first = SEL_W'(10);
      scan_last  = SEL_W'(5);
      scan_en    = 1'b1;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || en_b !== ALL_OPEN || cur_sel !== SEL_W'(5)) begin
         errors++;
         $display("FAIL bad_scan_order err=%b en_b=%h cur_sel=%0d need 1/all1/5", err, en_b, cur_sel);
      end
      for (int i = 1; i <= BREAK_CYC + 2; i++) begin
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || en_b !== ALL_OPEN || s_en !== 1'b0) begin
            errors++;
            $display("FAIL bad_scan_idle%0d err=%b en_b=%h s_en=%b need 0/all1/0", i, err, en_b, s_en);
         end
      end
      scan_en = 1'b0;
      @(negedge clk);
      scan_first = SEL_W'(0);
      scan_last  = SEL_W'(32);
      scan_en    = 1'b1;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || en_b !== ALL_OPEN) begin
         errors++;
         $display("FAIL bad_scan_range err=%b en_b=%h need 1/all1", err, en_b);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL bad_scan_range_after err=%b need 0", err);
      end
      scan_en = 1'b0;
      @(negedge clk);
      $display("invalid scan ranges rejected");
   endtask

   task automatic test_single_scan();
      logic [N_CH-1:0] exp_en;
      int ph;
      scan_first = SEL_W'(2);
      scan_last  = SEL_W'(2);
      dwell      = '0;
      scan_en    = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         ph     = (c - 1) % 5;
         exp_en = (ph < 4) ? ALL_OPEN : one_low(2);
         checks++;
         if (en_b !== exp_en || sample_pulse !== (ph == 4)) begin
            errors++;
            $display("FAIL single_scan_cyc%0d en_b=%h sp=%b need %h/%b", c, en_b, sample_pulse, exp_en, (ph == 4));
         end
      end
      off_req = 1'b1;
      @(negedge clk);
      off_req = 1'b0;
      scan_en = 1'b0;
      checks++;
      if (en_b !== ALL_OPEN || sample_pulse !== 1'b0 || settled !== 1'b0) begin
         errors++;
         $display("FAIL single_scan_off en_b=%h sp=%b settled=%b need all1/0/0", en_b, sample_pulse, settled);
      end
      $display("single-channel scan, dwell 0, off_req abort");
   endtask

   initial begin
      test_reset();
      test_select(3, -1);
      test_select(17, 3);
      test_noop();
      test_bad_sel();
      test_scan();
      test_off_break();
      test_bad_scan();
      test_single_scan();
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
